// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: ALU op codes, instruction
// field positions, default widths, output-slot states and an instruction
// decode helper.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned IMM_W_DEF  = 13;

  // Instruction word layout
  localparam int unsigned SEL_MSB     = 31;
  localparam int unsigned SEL_LSB     = 29;
  localparam int unsigned RD_MSB      = 28;
  localparam int unsigned RD_LSB      = 24;
  localparam int unsigned RS1_MSB     = 23;
  localparam int unsigned RS1_LSB     = 19;
  localparam int unsigned RS2_MSB     = 18;
  localparam int unsigned RS2_LSB     = 14;
  localparam int unsigned USE_IMM_BIT = 13;
  localparam int unsigned IMM_MSB     = 12;
  localparam int unsigned IMM_LSB     = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLT = 3'b010,
    ALU_MUL = 3'b011,
    ALU_DIV = 3'b100,
    ALU_AND = 3'b101,
    ALU_SHL = 3'b110,
    ALU_OR  = 3'b111
  } alu_sel_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [2:0]            sel;
    logic [REG_AW_DEF-1:0] rd;
    logic [REG_AW_DEF-1:0] rs1;
    logic [REG_AW_DEF-1:0] rs2;
    logic                  use_imm;
    logic [IMM_W_DEF-1:0]  imm;
  } instr_t;

  function automatic instr_t decode_instr(input logic [31:0] w);
    instr_t d;
    d.sel     = w[SEL_MSB:SEL_LSB];
    d.rd      = w[RD_MSB:RD_LSB];
    d.rs1     = w[RS1_MSB:RS1_LSB];
    d.rs2     = w[RS2_MSB:RS2_LSB];
    d.use_imm = w[USE_IMM_BIT];
    d.imm     = w[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: 2**REG_AW x DATA_W, two asynchronous read ports, one
// synchronous write port, r0 hardwired to zero, async active-low reset.
// Reads see a same-cycle write (write-through bypass).
// Ports:
//   clk, rst_n            clock / async active-low reset
//   rs1_addr, rs2_addr    read addresses
//   rs1_data, rs2_data    read data (bypassed)
//   we, waddr, wdata      write port (writes to r0 ignored)
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int unsigned NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic              wr_ok;

  assign wr_ok = we && (waddr != '0);

  always_comb begin
    rf_d = rf_q;
    if (wr_ok) rf_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) rs1_data = (wr_ok && waddr == rs1_addr) ? wdata : rf_q[rs1_addr];
    if (rs2_addr != '0) rs2_data = (wr_ok && waddr == rs2_addr) ? wdata : rf_q[rs2_addr];
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch/issue stage in front of the ALU. Decodes instr, reads the
// register file, picks register or sign-extended immediate for op2 and
// registers the operation into a valid/ready output slot. A per-register
// pending scoreboard stalls RAW/WAW hazards until writeback returns.
// Ports:
//   clk, rst_n               clock / async active-low reset
//   in_valid, in_ready, instr  instruction handshake
//   out_valid, out_ready     output slot handshake
//   op1, op2, sel, rd        operation toward the ALU
//   div_zero                 divide op with zero divisor (qualified by out_valid)
//   wb_en, wb_addr, wb_data  result writeback into the register file
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned IMM_W  = IMM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [2:0]        sel,
  output logic [REG_AW-1:0] rd,
  output logic              div_zero,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  localparam int unsigned NREG = 2 ** REG_AW;

  instr_t            dec;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] op2_next;
  logic [NREG-1:0]   wb_clr;
  logic [NREG-1:0]   pend_src;
  logic              haz;
  logic              slot_free;
  logic              accept;

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [2:0]        sel_q, sel_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              div_zero_q, div_zero_d;
  logic [NREG-1:0]   pend_q, pend_d;

  assign dec = decode_instr(instr);

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (dec.rs1),
    .rs2_addr (dec.rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_en),
    .waddr    (wb_addr),
    .wdata    (wb_data)
  );

  always_comb begin
    wb_clr = '0;
    for (int unsigned i = 0; i < NREG; i++) wb_clr[i] = wb_en && (wb_addr == REG_AW'(i));
  end

  // Sources see the writeback clear this cycle (data arrives via RF bypass);
  // rd does not, so a set and a clear never hit the same bit in one cycle.
  assign pend_src  = pend_q & ~wb_clr;
  assign haz       = pend_src[dec.rs1] || (!dec.use_imm && pend_src[dec.rs2]) || pend_q[dec.rd];
  assign slot_free = (state_q == SLOT_EMPTY) || out_ready;
  assign in_ready  = slot_free && !(in_valid && haz);
  assign accept    = in_valid && in_ready;

  assign op2_next = dec.use_imm ? {{(DATA_W-IMM_W){dec.imm[IMM_W-1]}}, dec.imm} : rs2_data;

  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    div_zero_d = div_zero_q;
    if (accept) begin
      state_d    = SLOT_FULL;
      op1_d      = rs1_data;
      op2_d      = op2_next;
      sel_d      = dec.sel;
      rd_d       = dec.rd;
      div_zero_d = (dec.sel == ALU_DIV) && (op2_next == '0);
    end else if (out_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    pend_d = pend_q & ~wb_clr;
    if (accept && dec.rd != '0) pend_d[dec.rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SLOT_EMPTY;
      op1_q      <= '0;
      op2_q      <= '0;
      sel_q      <= '0;
      rd_q       <= '0;
      div_zero_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      div_zero_q <= div_zero_d;
      pend_q     <= pend_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign sel       = sel_q;
  assign rd        = rd_q;
  assign div_zero  = div_zero_q && out_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, immediate sign extension,
// RAW stall with writeback bypass, backpressure, divide-by-zero flag, r0
// handling and reset while an operation is held.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [2:0]  sel;
  logic [4:0]  rd;
  logic        div_zero;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(
    .DATA_W (32),
    .REG_AW (5),
    .IMM_W  (13)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op1       (op1),
    .op2       (op2),
    .sel       (sel),
    .rd        (rd),
    .div_zero  (div_zero),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] s, input logic [4:0] d, input logic [4:0] a,
                                     input logic [4:0] b, input logic ui, input logic [12:0] imm);
    return {s, d, a, b, ui, imm};
  endfunction

  // advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    step(); step();
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_op1", op1, 32'd0);
    check_val("rst_op2", op2, 32'd0);
    check_val("rst_sel", {29'd0, sel}, 32'd0);
    check_val("rst_rd", {27'd0, rd}, 32'd0);
    check_val("rst_div_zero", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: sign-extended immediate, rd=3 becomes pending
    in_valid = 1'b1; instr = mk(3'b000, 5'd3, 5'd0, 5'd0, 1'b1, 13'h1FFF);
    #1 check_val("t1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_val("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check_val("t1_op1", op1, 32'd0);
    check_val("t1_op2", op2, 32'hFFFF_FFFF);
    check_val("t1_rd", {27'd0, rd}, 32'd3);
    instr = mk(3'b000, 5'd9, 5'd3, 5'd0, 1'b1, 13'd0);
    #1 check_val("t1_pend3_stall", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_AAAA;
    step();
    wb_en = 1'b0;

    // 2: RAW on r5 released by writeback with same-cycle bypass
    in_valid = 1'b1; instr = mk(3'b000, 5'd5, 5'd0, 5'd0, 1'b1, 13'd1);
    step();
    instr = mk(3'b000, 5'd6, 5'd5, 5'd0, 1'b1, 13'd7);
    #1 check_val("t2_stall_a", {31'd0, in_ready}, 32'd0);
    step();
    check_val("t2_stall_b", {31'd0, in_ready}, 32'd0);
    check_val("t2_drained", {31'd0, out_valid}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
    #1 check_val("t2_bypass_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; wb_en = 1'b0;
    check_val("t2_out_valid", {31'd0, out_valid}, 32'd1);
    check_val("t2_op1", op1, 32'h0000_1234);
    check_val("t2_op2", op2, 32'd7);
    check_val("t2_rd", {27'd0, rd}, 32'd6);
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000_0066;
    step();
    wb_en = 1'b0;
    check_val("t2_empty", {31'd0, out_valid}, 32'd0);

    // 3: backpressure holds the slot, then back-to-back issue
    out_ready = 1'b0; in_valid = 1'b1; instr = mk(3'b001, 5'd8, 5'd5, 5'd6, 1'b0, 13'd0);
    step();
    check_val("t3_op1", op1, 32'h0000_1234);
    check_val("t3_op2", op2, 32'h0000_0066);
    check_val("t3_sel", {29'd0, sel}, 32'd1);
    instr = mk(3'b000, 5'd9, 5'd5, 5'd0, 1'b1, 13'd5);
    for (int i = 0; i < 4; i++) begin
      #1 check_val("t3_hold_ready", {31'd0, in_ready}, 32'd0);
      step();
      check_val("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check_val("t3_hold_op1", op1, 32'h0000_1234);
      check_val("t3_hold_op2", op2, 32'h0000_0066);
      check_val("t3_hold_rd", {27'd0, rd}, 32'd8);
    end
    out_ready = 1'b1;
    #1 check_val("t3_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_val("t3_b2b_valid", {31'd0, out_valid}, 32'd1);
    check_val("t3_b2b_op2", op2, 32'd5);
    check_val("t3_b2b_rd", {27'd0, rd}, 32'd9);
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'd0;
    step();
    check_val("t3_drain", {31'd0, out_valid}, 32'd0);
    wb_addr = 5'd9;
    step();
    wb_en = 1'b0;

    // 4: divide-by-zero flag
    in_valid = 1'b1; instr = mk(3'b100, 5'd10, 5'd5, 5'd0, 1'b0, 13'd0);
    step();
    check_val("t4_dz_set", {31'd0, div_zero}, 32'd1);
    check_val("t4_sel", {29'd0, sel}, 32'd4);
    instr = mk(3'b100, 5'd11, 5'd5, 5'd0, 1'b1, 13'd2);
    step();
    in_valid = 1'b0;
    check_val("t4_dz_clear", {31'd0, div_zero}, 32'd0);
    check_val("t4_op2", op2, 32'd2);
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'd0;
    step();
    wb_addr = 5'd11;
    step();
    wb_en = 1'b0;

    // 5: r0 is never written nor pending
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_DEAD;
    in_valid = 1'b1; instr = mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 13'd0);
    step();
    wb_en = 1'b0;
    check_val("t5_op1_bypass", op1, 32'd0);
    check_val("t5_op2_bypass", op2, 32'd0);
    instr = mk(3'b000, 5'd12, 5'd0, 5'd0, 1'b0, 13'd0);
    #1 check_val("t5_no_pend0", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_val("t5_op1", op1, 32'd0);
    check_val("t5_op2", op2, 32'd0);

    // 6: reset while an op is held with r7 pending
    out_ready = 1'b0; in_valid = 1'b1; instr = mk(3'b000, 5'd7, 5'd0, 5'd0, 1'b1, 13'd1);
    step();
    in_valid = 1'b0;
    check_val("t6_held", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_val("t6_async_valid", {31'd0, out_valid}, 32'd0);
    check_val("t6_async_op2", op2, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1; in_valid = 1'b1; instr = mk(3'b000, 5'd14, 5'd7, 5'd5, 1'b0, 13'd0);
    #1 check_val("t6_no_stall", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_val("t6_valid", {31'd0, out_valid}, 32'd1);
    check_val("t6_op1", op1, 32'd0);
    check_val("t6_rf_cleared", op2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
